// File: rtl/div.sv
// Multi-cycle restoring divider: one quotient bit per cycle, signed or unsigned,
// with divide-by-zero short path, pipeline-flush cancel and {remainder, quotient} result.
module div #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] dividend_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quot_reg;
  logic             neg_quot_reg;
  logic             neg_rem_reg;

  logic             op1_neg;
  logic             op2_neg;
  logic [WIDTH-1:0] op1_mag;
  logic [WIDTH-1:0] op2_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  // The core always divides magnitudes; signs are reapplied once at the end.
  assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign op1_mag = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_mag = op2_neg ? -opdata2_i : opdata2_i;

  // A set top bit of diff means the trial subtraction went negative.
  assign shifted = {rem_reg, dividend_reg[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor_reg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_FREE;
      cnt_reg      <= '0;
      dividend_reg <= '0;
      divisor_reg  <= '0;
      rem_reg      <= '0;
      quot_reg     <= '0;
      neg_quot_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
      result_o     <= '0;
      ready_o      <= 1'b0;
    end else begin
      case (state_reg)
        S_FREE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (start_i && !annul_i) begin
            dividend_reg <= op1_mag;
            divisor_reg  <= op2_mag;
            neg_quot_reg <= op1_neg ^ op2_neg;
            neg_rem_reg  <= op1_neg;
            rem_reg      <= '0;
            quot_reg     <= '0;
            cnt_reg      <= '0;
            state_reg    <= (opdata2_i == '0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: begin
          if (annul_i) begin
            state_reg <= S_FREE;
          end else begin
            rem_reg   <= '0;
            quot_reg  <= '0;
            state_reg <= S_END;
          end
        end
        S_ON: begin
          if (annul_i) begin
            state_reg <= S_FREE;
          end else if (cnt_reg == CNT_LAST) begin
            quot_reg  <= neg_quot_reg ? -quot_reg : quot_reg;
            rem_reg   <= neg_rem_reg ? -rem_reg : rem_reg;
            state_reg <= S_END;
          end else begin
            rem_reg      <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            quot_reg     <= {quot_reg[WIDTH-2:0], ~diff[WIDTH]};
            dividend_reg <= {dividend_reg[WIDTH-2:0], 1'b0};
            cnt_reg      <= cnt_reg + CW'(1);
          end
        end
        S_END: begin
          if (start_i) begin
            result_o <= {rem_reg, quot_reg};
            ready_o  <= 1'b1;
          end else begin
            result_o  <= '0;
            ready_o   <= 1'b0;
            state_reg <= S_FREE;
          end
        end
        default: state_reg <= S_FREE;
      endcase
    end
  end

endmodule
